// File: rtl/uart_bridge_pkg.sv
// Shared command/response codes, FSM state encodings and a byte-lane helper
// used by the UART-to-register bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;  // 'W'
  localparam logic [7:0] CmdRead  = 8'h52;  // 'R'
  localparam logic [7:0] RespOk   = 8'h4B;  // 'K'
  localparam logic [7:0] RespErr  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StBusWr,
    StBusRd,
    StRdWait,
    StSendResp,
    StSendData
  } state_e;

  typedef enum logic [2:0] {
    RxArm,
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  function automatic logic [7:0] byte_sel(logic [31:0] word, logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_bridge_rx.sv
// 8N1 serial receiver: synchronizes the line, validates the start bit at
// mid-bit and emits a byte with either a valid or a framing-error pulse.
module uart_bridge_rx
  import uart_bridge_pkg::*;
#(
  parameter int unsigned BaudDiv = 512
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(BaudDiv);
  localparam logic [CntW-1:0] CntLast = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BaudDiv / 2 - 1);

  logic            meta_q, sync_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            cnt_tick;

  assign cnt_tick    = (cnt_q == CntLast);
  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxArm;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      // A full bit-time of idle-high is required after reset, so a frame already
      // in flight at reset release is never taken as a fresh start bit.
      RxArm: begin
        if (!sync_q) begin
          cnt_d = '0;
        end else if (cnt_tick) begin
          cnt_d   = '0;
          state_d = RxIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxIdle: begin
        if (prev_q && !sync_q) begin
          cnt_d   = '0;
          state_d = RxStart;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_tick) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_tick) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxArm;
    endcase
  end

endmodule

// File: rtl/uart_bridge.sv
// UART command bridge: decodes 'W'/'R' commands from the serial receiver into
// single-cycle register-bus accesses and serializes the response bytes.
module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 512,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [4:0]  addr,
  output logic        re,
  output logic        we,
  output logic [31:0] wd,
  input  logic [31:0] rd,
  output logic        busy
);

  localparam int unsigned CntW          = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntLast   = CntW'(BAUD_DIV - 1);
  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned ToW           = $clog2(TimeoutCycles);
  localparam logic [ToW-1:0] ToLast     = ToW'(TimeoutCycles - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_bridge_rx #(
    .BaudDiv(BAUD_DIV)
  ) u_rx (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .rx_i       (uart_rx),
    .byte_o     (rx_byte),
    .valid_o    (rx_valid),
    .frame_err_o(rx_ferr)
  );

  state_e          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [4:0]      cmd_addr_q, cmd_addr_d;
  logic [31:0]     wbuf_q, wbuf_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      next_idx;
  logic [31:0]     rdata_q, rdata_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     wd_q, wd_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;

  logic            tx_active_q, tx_active_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_load, tx_done;
  logic [7:0]      tx_byte;

  assign next_idx = idx_q + 2'd1;
  assign tx_done  = tx_active_q && (tx_cnt_q == CntLast) && (tx_bit_q == 4'd9);
  assign uart_tx  = tx_active_q ? tx_shift_q[0] : 1'b1;
  assign addr     = addr_q;
  assign wd       = wd_q;
  assign we       = (state_q == StBusWr);
  assign re       = (state_q == StBusRd);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      cmd_addr_q  <= '0;
      wbuf_q      <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      to_cnt_q    <= '0;
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      wbuf_q      <= wbuf_d;
      idx_q       <= idx_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      to_cnt_q    <= to_cnt_d;
      tx_active_q <= tx_active_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  // Command FSM. addr/wd only change on entry to a bus state, so aborted
  // commands leave the bus outputs untouched.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cmd_addr_d = cmd_addr_q;
    wbuf_d     = wbuf_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    to_cnt_d   = to_cnt_q;
    tx_load    = 1'b0;
    tx_byte    = RespErr;
    unique case (state_q)
      StIdle: begin
        if (rx_ferr) begin
          state_d = StSendResp;
          tx_load = 1'b1;
        end else if (rx_valid) begin
          if (rx_byte == CmdWrite || rx_byte == CmdRead) begin
            state_d  = StGetAddr;
            is_wr_d  = (rx_byte == CmdWrite);
            to_cnt_d = '0;
          end else begin
            state_d = StSendResp;
            tx_load = 1'b1;
          end
        end
      end
      StGetAddr: begin
        if (rx_ferr) begin
          state_d = StSendResp;
          tx_load = 1'b1;
        end else if (rx_valid) begin
          cmd_addr_d = rx_byte[4:0];
          to_cnt_d   = '0;
          idx_d      = '0;
          if (is_wr_q) begin
            state_d = StGetData;
          end else begin
            state_d = StBusRd;
            addr_d  = rx_byte[4:0];
          end
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StGetData: begin
        if (rx_ferr) begin
          state_d = StSendResp;
          tx_load = 1'b1;
        end else if (rx_valid) begin
          wbuf_d[{idx_q, 3'b000} +: 8] = rx_byte;
          to_cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = StBusWr;
            addr_d  = cmd_addr_q;
            wd_d    = {rx_byte, wbuf_q[23:0]};
          end else begin
            idx_d = next_idx;
          end
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StBusWr: begin
        state_d = StSendResp;
        tx_load = 1'b1;
        tx_byte = RespOk;
      end
      StBusRd: state_d = StRdWait;
      StRdWait: begin
        rdata_d = rd;
        idx_d   = '0;
        state_d = StSendData;
        tx_load = 1'b1;
        tx_byte = rd[7:0];
      end
      StSendData: begin
        if (tx_done) begin
          if (idx_q == 2'd3) begin
            state_d = StIdle;
          end else begin
            idx_d   = next_idx;
            tx_load = 1'b1;
            tx_byte = byte_sel(rdata_q, next_idx);
          end
        end
      end
      StSendResp: begin
        if (tx_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Loading on the stop bit's final cycle keeps consecutive bytes gap-free.
  always_comb begin
    tx_active_d = tx_active_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_load) begin
      tx_active_d = 1'b1;
      tx_shift_d  = {1'b1, tx_byte, 1'b0};
      tx_bit_d    = '0;
      tx_cnt_d    = '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == CntLast) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) begin
          tx_active_d = 1'b0;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bridge.sv
// Bench for uart_bridge: command vectors with a response scoreboard, a small
// register-file responder, plus timeout and reset sequences.
module tb_uart_bridge;

  localparam int unsigned BaudDiv     = 16;
  localparam int unsigned TimeoutBits = 32;
  localparam int          RespBudget  = 4000;

  typedef struct packed {
    int unsigned     n_cmd;
    logic [5:0][7:0] cmd;       // cmd[0] is sent first
    logic            bad_stop;  // drive the last byte's stop bit low
    int unsigned     n_we;
    int unsigned     n_re;
    logic [4:0]      bus_addr;
    logic [31:0]     bus_wd;
    int unsigned     n_resp;
    logic [3:0][7:0] resp;      // resp[0] expected first
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx, re, we, busy;
  logic [4:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  always #5 clk = ~clk;

  uart_bridge #(
    .BAUD_DIV    (BaudDiv),
    .TIMEOUT_BITS(TimeoutBits)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .addr   (addr),
    .re     (re),
    .we     (we),
    .wd     (wd),
    .rd     (rd),
    .busy   (busy)
  );

  // Responder: read data is valid only in the cycle after the re pulse.
  logic [31:0] regs [32];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) regs[5] <= 32'hCAFE_F00D;
    if (we) regs[addr] <= wd;
    rd <= re ? regs[addr] : 32'h0BAD_0BAD;
  end

  int unsigned we_cyc = 0, re_cyc = 0, both_cyc = 0;
  logic [4:0]  w_addr = '0, r_addr = '0;
  logic [31:0] w_data = '0;
  always @(negedge clk) begin
    if (we) begin
      we_cyc <= we_cyc + 1;
      w_addr <= addr;
      w_data <= wd;
    end
    if (re) begin
      re_cyc <= re_cyc + 1;
      r_addr <= addr;
    end
    if (we && re) both_cyc <= both_cyc + 1;
  end

  int unsigned total = 0, bad = 0;
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int unsigned nc, input logic [47:0] c, input logic bs,
                              input int unsigned nw, input int unsigned nr, input logic [4:0] a,
                              input logic [31:0] d, input int unsigned nrs, input logic [31:0] r);
    vec_t v;
    v.n_cmd    = nc;
    v.cmd      = c;
    v.bad_stop = bs;
    v.n_we     = nw;
    v.n_re     = nr;
    v.bus_addr = a;
    v.bus_wd   = d;
    v.n_resp   = nrs;
    v.resp     = r;
    return v;
  endfunction

  task automatic bit_out(input logic v);
    uart_rx = v;
    repeat (BaudDiv) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    uart_rx = 1'b1;
  endtask

  task automatic send_cmd(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < int'(v.n_cmd); i++)
      send_byte(v.cmd[i], !(v.bad_stop && i == int'(v.n_cmd) - 1));
  endtask

  // Pops each expected byte and compares it with the next frame on uart_tx.
  task automatic collect_resp(input string name);
    logic [7:0] want, got;
    logic       start, stop;
    int         t;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      t = 0;
      while (uart_tx === 1'b1 && t < RespBudget) begin
        @(negedge clk);
        t++;
      end
      if (t >= RespBudget) begin
        total++;
        bad++;
        $display("FAIL %s resp: no start bit, want byte 0x%0h", name, want);
        exp_q.delete();
      end else begin
        repeat (BaudDiv / 2) @(negedge clk);
        start = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BaudDiv) @(negedge clk);
          got[i] = uart_tx;
        end
        repeat (BaudDiv) @(negedge clk);
        stop = uart_tx;
        check({name, " resp {start,stop,byte}"}, 32'({start, stop, got}),
              32'({1'b0, 1'b1, want}));
      end
    end
  endtask

  task automatic quiet(input int cycles, input string name);
    int lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check(name, 32'(lows), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int unsigned we0, re0;
    we0 = we_cyc;
    re0 = re_cyc;
    for (int i = 0; i < int'(v.n_resp); i++) exp_q.push_back(v.resp[i]);
    fork
      send_cmd(v);
      collect_resp(name);
    join
    repeat (BaudDiv) @(negedge clk);
    check({name, " busy"}, 32'(busy), 32'h0);
    check({name, " we cycles"}, we_cyc - we0, v.n_we);
    check({name, " re cycles"}, re_cyc - re0, v.n_re);
    if (v.n_we != 0) begin
      check({name, " write addr"}, 32'(w_addr), 32'(v.bus_addr));
      check({name, " write data"}, w_data, v.bus_wd);
    end
    if (v.n_re != 0) check({name, " read addr"}, 32'(r_addr), 32'(v.bus_addr));
    quiet(4 * BaudDiv, {name, " tx idle"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [8];
    int unsigned we0, re0;

    vecs[0] = mk(6, 48'h1234_5678_0357, 1'b0, 1, 0, 5'h03, 32'h1234_5678, 1, 32'h4B);
    vecs[1] = mk(2, 48'h0552, 1'b0, 0, 1, 5'h05, 32'h0, 4, 32'hCAFE_F00D);
    vecs[2] = mk(1, 48'h41, 1'b0, 0, 0, 5'h00, 32'h0, 1, 32'h3F);
    vecs[3] = mk(1, 48'h57, 1'b1, 0, 0, 5'h00, 32'h0, 1, 32'h3F);
    vecs[4] = mk(2, 48'h0352, 1'b0, 0, 1, 5'h03, 32'h0, 4, 32'h1234_5678);
    vecs[5] = mk(6, 48'hDEAD_BEEF_E157, 1'b0, 1, 0, 5'h01, 32'hDEAD_BEEF, 1, 32'h4B);
    vecs[6] = mk(2, 48'hA552, 1'b0, 0, 1, 5'h05, 32'h0, 4, 32'hCAFE_F00D);
    vecs[7] = mk(2, 48'h0357, 1'b1, 0, 0, 5'h00, 32'h0, 1, 32'h3F);

    // Reset state
    preload = 1'b1;
    repeat (4) @(negedge clk);
    preload = 1'b0;
    check("reset uart_tx", 32'(uart_tx), 32'h1);
    check("reset busy", 32'(busy), 32'h0);
    check("reset we", 32'(we), 32'h0);
    check("reset re", 32'(re), 32'h0);
    check("reset addr", 32'(addr), 32'h0);
    check("reset wd", wd, 32'h0);
    rstn = 1'b1;
    repeat (4 * BaudDiv) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Partial write followed by silence must abort without any response.
    we0 = we_cyc;
    re0 = re_cyc;
    send_cmd(mk(3, 48'hAA_0157, 1'b0, 0, 0, 5'h0, 32'h0, 0, 32'h0));
    quiet(600, "timeout tx idle");
    check("timeout busy", 32'(busy), 32'h0);
    check("timeout we cycles", we_cyc - we0, 32'h0);
    check("timeout re cycles", re_cyc - re0, 32'h0);
    run_vec(mk(2, 48'h0152, 1'b0, 0, 1, 5'h01, 32'h0, 4, 32'hDEAD_BEEF), "after_timeout");

    // Reset during the third data byte of a write.
    we0 = we_cyc;
    fork
      send_cmd(mk(5, 48'h33_2211_0257, 1'b0, 0, 0, 5'h0, 32'h0, 0, 32'h0));
      begin
        repeat (4 * 10 * BaudDiv + 5 * BaudDiv) @(negedge clk);
        rstn = 1'b0;
      end
    join
    check("midreset uart_tx", 32'(uart_tx), 32'h1);
    check("midreset busy", 32'(busy), 32'h0);
    check("midreset addr", 32'(addr), 32'h0);
    check("midreset wd", wd, 32'h0);

    // Line already low at release must not be decoded as a start bit.
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (3 * BaudDiv) @(negedge clk);
    uart_rx = 1'b1;
    quiet(25 * BaudDiv, "stale start tx idle");
    check("stale start busy", 32'(busy), 32'h0);
    check("midreset we cycles", we_cyc - we0, 32'h0);

    run_vec(mk(6, 48'hA5A5_5A5A_0457, 1'b0, 1, 0, 5'h04, 32'hA5A5_5A5A, 1, 32'h4B),
            "write_after_reset");
    run_vec(mk(2, 48'h0452, 1'b0, 0, 1, 5'h04, 32'h0, 4, 32'hA5A5_5A5A), "read_after_reset");

    check("we/re overlap cycles", both_cyc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bridge.md
UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 512, clock cycles per serial bit (min 8).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32, inter-byte timeout in bit-times.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port uart_rx  input  1  serial command input, 8N1, idle high.
REQ-006 SHALL have port uart_tx  output  1  serial response output, 8N1, idle high.
REQ-007 SHALL have port addr  output  5  simple-interface register address.
REQ-008 SHALL have port re  output  1  read enable, one-cycle pulse.
REQ-009 SHALL have port we  output  1  write enable, one-cycle pulse.
REQ-010 SHALL have port wd  output  32  write data.
REQ-011 SHALL have port rd  input  32  read data from responder.
REQ-012 SHALL have port busy  output  1  high while a command is in progress (not IDLE).

Function
REQ-013 SHALL act as simple-interface initiator driven by UART commands; responder is any register block on the same bus.
REQ-014 uart_rx SHALL pass a 2-flop synchronizer; start = synchronized falling edge while receiver idle.
REQ-015 Receiver SHALL re-check start at BAUD_DIV/2 (high -> discard, return idle), then sample 8 data bits LSB first and stop bit every BAUD_DIV cycles.
REQ-016 Stop bit sampled 0 SHALL be a framing error: byte discarded, command aborted, response 0x3F.
REQ-017 Command protocol: 0x57 ('W'), addr byte, 4 data bytes LSB first; 0x52 ('R'), addr byte; addr uses bits [4:0], bits [7:5] ignored.
REQ-018 FSM states: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND_RESP, SEND_DATA.
REQ-019 IDLE: 'W' or 'R' -> GET_ADDR; any other byte -> SEND_RESP with 0x3F.
REQ-020 GET_ADDR: latch addr; 'W' -> GET_DATA (byte count 0), 'R' -> BUS_RD.
REQ-021 GET_DATA: shift byte n into wd[8n+7:8n]; after n=3 -> BUS_WR.
REQ-022 BUS_WR: we=1 exactly one cycle with addr/wd stable -> SEND_RESP with 0x4B ('K').
REQ-023 BUS_RD: re=1 exactly one cycle -> RD_WAIT; rd SHALL be captured at end of the cycle following the re pulse -> SEND_DATA.
REQ-024 SEND_DATA: transmit captured word as 4 bytes LSB first, then -> IDLE.
REQ-025 SEND_RESP: transmit one byte, then -> IDLE.
REQ-026 Transmitter: start bit, 8 data bits LSB first, 1 stop bit, each BAUD_DIV cycles; back-to-back bytes with no idle gap.
REQ-027 Bytes received while in BUS_*, RD_WAIT, SEND_* SHALL be dropped.
REQ-028 In GET_ADDR/GET_DATA, no byte within TIMEOUT_BITS*BAUD_DIV cycles SHALL abort silently to IDLE (no response, no bus access).
REQ-029 we and re SHALL never be high in the same cycle; wd/addr hold last values between accesses.

Reset
REQ-030 rstn low at a clock edge SHALL force IDLE, uart_tx=1, re=0, we=0, addr=0, wd=0, busy=0, clear receiver/transmitter/counters, including mid-byte or mid-command.
REQ-031 After rstn release, a byte whose start bit precedes release SHALL not be decoded; first valid falling edge after release starts reception.

Structure
REQ-032 Package uart_bridge_pkg SHALL hold command codes (0x57, 0x52), response codes (0x4B, 0x3F) and FSM state enum.
REQ-033 Serial receiver (REQ-014..016) SHALL be sub-module uart_bridge_rx, outputs byte, valid pulse, frame_err pulse.
REQ-034 Transmitter and command FSM SHALL reside in uart_bridge.

Verification (BAUD_DIV=16, TIMEOUT_BITS=32, bench model register file)
REQ-035 Send 57 03 78 56 34 12 -> one we pulse, addr=0x03, wd=0x12345678; uart_tx returns 4B.
REQ-036 Preload reg 0x05=0xCAFEF00D; send 52 05 -> one re pulse, addr=0x05; uart_tx returns 0D F0 FE CA.
REQ-037 Send 41 -> no re/we; uart_tx returns 3F; busy low after stop bit.
REQ-038 Send 57 01 AA then idle 600 cycles -> no we, no response, busy low; next 52 01 served normally.
REQ-039 Send 57 with stop bit forced 0 -> returns 3F, no bus access.
REQ-040 Assert rstn low during data byte 2 of a write -> uart_tx=1, busy=0, no we; subsequent full write succeeds.
